// File: rtl/canvas_pkg.sv
// -----------------------------------------------------------------------------
// canvas_pkg
// Shared definitions for the canvas write engine and the scan-out colour path:
// canvas geometry, the canvas screen offset, pixel/address types, the rectangle
// writer state encoding and the 16-entry palette index enumeration.
// -----------------------------------------------------------------------------
package canvas_pkg;

    // Canvas geometry in pixels and its placement on the VGA screen.
    localparam int CANVAS_W      = 440;
    localparam int CANVAS_H      = 280;
    localparam int CANVAS_X0     = 100;
    localparam int CANVAS_Y0     = 100;
    localparam int CANVAS_ADDR_W = 17;

    typedef logic [3:0]               color_idx_t;
    typedef logic [CANVAS_ADDR_W-1:0] canvas_addr_t;

    // Rectangle writer sequencing.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ORDER = 3'd1,
        ST_CLIP  = 3'd2,
        ST_SETUP = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } wr_state_t;

    // Palette indices; plane 0 stores bits [1:0], plane 1 stores bits [3:2].
    typedef enum logic [3:0] {
        RED        = 4'd0,
        ORANGE     = 4'd1,
        YELLOW     = 4'd2,
        GREEN      = 4'd3,
        CYAN       = 4'd4,
        BLUE       = 4'd5,
        PURPLE     = 4'd6,
        PINK       = 4'd7,
        WHITE      = 4'd8,
        LIGHT_GRAY = 4'd9,
        GRAY       = 4'd10,
        DARK_GRAY  = 4'd11,
        BLACK      = 4'd12,
        TAN        = 4'd13,
        OLIVE      = 4'd14,
        BROWN      = 4'd15
    } palette_t;

endpackage

// File: rtl/rect_order_clip.sv
// -----------------------------------------------------------------------------
// rect_order_clip
// Purely combinational corner ordering, clamping and empty detection for a
// rectangle-fill command. The parent registers the ordered corners in one
// cycle and the clamped corners / empty flag in the next.
//
// Ports:
//   a_x, a_y, b_x, b_y   : the two inclusive corners, any order
//   lo_x, lo_y           : smaller coordinate of each axis
//   hi_x, hi_y           : larger coordinate of each axis
//   hi_x_clamped         : hi_x limited to CANVAS_W-1
//   hi_y_clamped         : hi_y limited to CANVAS_H-1
//   empty                : the low corner lies outside the canvas
// -----------------------------------------------------------------------------
module rect_order_clip
    import canvas_pkg::*;
#(
    parameter int CANVAS_W = canvas_pkg::CANVAS_W,
    parameter int CANVAS_H = canvas_pkg::CANVAS_H
) (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic [9:0] lo_x,
    output logic [9:0] lo_y,
    output logic [9:0] hi_x,
    output logic [9:0] hi_y,
    output logic [9:0] hi_x_clamped,
    output logic [9:0] hi_y_clamped,
    output logic       empty
);

    localparam logic [9:0] X_LIM_C = 10'(CANVAS_W);
    localparam logic [9:0] Y_LIM_C = 10'(CANVAS_H);
    localparam logic [9:0] X_MAX_C = 10'(CANVAS_W - 1);
    localparam logic [9:0] Y_MAX_C = 10'(CANVAS_H - 1);

    // Unsigned swap of each axis so that lo <= hi.
    always_comb begin
        if (a_x <= b_x) begin
            lo_x = a_x;
            hi_x = b_x;
        end else begin
            lo_x = b_x;
            hi_x = a_x;
        end
        if (a_y <= b_y) begin
            lo_y = a_y;
            hi_y = b_y;
        end else begin
            lo_y = b_y;
            hi_y = a_y;
        end
    end

    // Clamp the far corner to the last canvas pixel; a low corner beyond the
    // canvas means nothing of the rectangle is visible.
    always_comb begin
        if (hi_x >= X_LIM_C) begin
            hi_x_clamped = X_MAX_C;
        end else begin
            hi_x_clamped = hi_x;
        end
        if (hi_y >= Y_LIM_C) begin
            hi_y_clamped = Y_MAX_C;
        end else begin
            hi_y_clamped = hi_y;
        end
        empty = (lo_x >= X_LIM_C) || (lo_y >= Y_LIM_C);
    end

endmodule

// File: rtl/canvas_rect_writer.sv
// -----------------------------------------------------------------------------
// canvas_rect_writer
// Write-side engine for the two 2-bit canvas RAM planes. Accepts one
// rectangle-fill command at a time, orders and clips its corners, then walks
// the rectangle in raster order issuing one RAM write per granted cycle.
//
// Ports:
//   Clk, Reset_n         : clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready  : command handshake; ready only while idle
//   cmd_x0..cmd_y1       : inclusive corners, canvas relative, any order
//   cmd_color            : palette index
//   abort                : cancel the running command (ignored when idle)
//   wr_grant             : canvas RAM port available this cycle
//   wr_en, wr_addr       : RAM write strobe and address (y*CANVAS_W + x)
//   ramIn, ramIn2        : plane-0 / plane-1 data (colour bits [1:0] / [3:2])
//   busy                 : engine not idle
//   done                 : one-cycle pulse after the last pixel is written
// -----------------------------------------------------------------------------
module canvas_rect_writer
    import canvas_pkg::*;
#(
    parameter int CANVAS_W = canvas_pkg::CANVAS_W,
    parameter int CANVAS_H = canvas_pkg::CANVAS_H,
    parameter int ADDR_W   = canvas_pkg::CANVAS_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_x1,
    input  logic [9:0]        cmd_y1,
    input  logic [3:0]        cmd_color,
    input  logic              abort,
    input  logic              wr_grant,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        ramIn,
    output logic [1:0]        ramIn2,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ROW_STEP_C = ADDR_W'(CANVAS_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE_C = ADDR_W'(1'b1);

    wr_state_t         state_r;
    logic [9:0]        x0_r;
    logic [9:0]        y0_r;
    logic [9:0]        x1_r;
    logic [9:0]        y1_r;
    logic [9:0]        cx_r;
    logic [9:0]        cy_r;
    color_idx_t        color_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              done_r;

    logic [ADDR_W-1:0] row_base_s;
    logic [ADDR_W-1:0] next_row_s;
    logic [9:0]        lo_x_s;
    logic [9:0]        lo_y_s;
    logic [9:0]        hi_x_s;
    logic [9:0]        hi_y_s;
    logic [9:0]        hi_x_clamped_s;
    logic [9:0]        hi_y_clamped_s;
    logic              empty_s;
    logic              abort_s;
    logic              wr_en_s;

    rect_order_clip #(
        .CANVAS_W (CANVAS_W),
        .CANVAS_H (CANVAS_H)
    ) u_order_clip (
        .a_x          (x0_r),
        .a_y          (y0_r),
        .b_x          (x1_r),
        .b_y          (y1_r),
        .lo_x         (lo_x_s),
        .lo_y         (lo_y_s),
        .hi_x         (hi_x_s),
        .hi_y         (hi_y_s),
        .hi_x_clamped (hi_x_clamped_s),
        .hi_y_clamped (hi_y_clamped_s),
        .empty        (empty_s)
    );

    // y0 * CANVAS_W as a sum of shifted copies of y0, one per set bit of the
    // constant width, so synthesis builds a small adder tree.
    always_comb begin
        row_base_s = '0;
        for (int i = 0; i < 11; i++) begin
            if (CANVAS_W[i]) begin
                row_base_s = row_base_s + (ADDR_W'(y0_r) << i);
            end else begin
                row_base_s = row_base_s;
            end
        end
    end

    // Start of the next raster row; used when the column counter wraps.
    always_comb begin
        next_row_s = row_base_r + ROW_STEP_C;
    end

    // Abort only matters while a command is running; a write is suppressed in
    // the abort cycle even if the RAM port is granted.
    always_comb begin
        abort_s = abort && (state_r != ST_IDLE);
        wr_en_s = (state_r == ST_WRITE) && wr_grant && !abort;
    end

    // Command sequencer: latch, order, clip, set up addressing, walk pixels.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            x0_r       <= 10'd0;
            y0_r       <= 10'd0;
            x1_r       <= 10'd0;
            y1_r       <= 10'd0;
            cx_r       <= 10'd0;
            cy_r       <= 10'd0;
            color_r    <= 4'd0;
            row_base_r <= '0;
            wr_addr_r  <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            x0_r    <= cmd_x0;
                            y0_r    <= cmd_y0;
                            x1_r    <= cmd_x1;
                            y1_r    <= cmd_y1;
                            color_r <= cmd_color;
                            state_r <= ST_ORDER;
                        end
                    end
                    ST_ORDER: begin
                        x0_r    <= lo_x_s;
                        y0_r    <= lo_y_s;
                        x1_r    <= hi_x_s;
                        y1_r    <= hi_y_s;
                        state_r <= ST_CLIP;
                    end
                    ST_CLIP: begin
                        // Corners are already ordered, so the clip block sees
                        // them unchanged and only clamps / flags emptiness.
                        if (empty_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            x1_r    <= hi_x_clamped_s;
                            y1_r    <= hi_y_clamped_s;
                            state_r <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        row_base_r <= row_base_s;
                        wr_addr_r  <= row_base_s + ADDR_W'(x0_r);
                        cx_r       <= x0_r;
                        cy_r       <= y0_r;
                        state_r    <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        if (wr_en_s) begin
                            if (cx_r != x1_r) begin
                                cx_r      <= cx_r + 10'd1;
                                wr_addr_r <= wr_addr_r + ADDR_ONE_C;
                            end else if (cy_r != y1_r) begin
                                cx_r       <= x0_r;
                                cy_r       <= cy_r + 10'd1;
                                row_base_r <= next_row_s;
                                wr_addr_r  <= next_row_s + ADDR_W'(x0_r);
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign wr_en     = wr_en_s;
    assign wr_addr   = wr_addr_r;
    assign ramIn     = color_r[1:0];
    assign ramIn2    = color_r[3:2];
    assign done      = done_r;

endmodule

// File: tb/tb_canvas_rect_writer.sv
// -----------------------------------------------------------------------------
// tb_canvas_rect_writer
// Directed bench for canvas_rect_writer. Cycle indices n count rising edges
// after the handshake edge (n=0 is the ORDER cycle), so a granted fill writes
// first at n=3 and an empty rectangle reaches DONE at n=2.
// -----------------------------------------------------------------------------
module tb_canvas_rect_writer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0;
    logic [9:0]  cmd_y0;
    logic [9:0]  cmd_x1;
    logic [9:0]  cmd_y1;
    logic [3:0]  cmd_color;
    logic        abort;
    logic        wr_grant;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [1:0]  ramIn;
    logic [1:0]  ramIn2;
    logic        busy;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Results of the most recent run_cmd call.
    logic [16:0] wr_q [$];
    logic [16:0] addr_at [0:63];
    int          first_wr_n;
    int          done_n;
    int          gap_cnt;
    int          color_bad;
    logic        timeout_f;
    logic        aborted_f;
    logic        abort_wr_en;
    logic        ready_in_done;
    logic        hs_ready;
    logic [16:0] rev_exp [0:5];

    localparam logic [63:0] GRANT_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    canvas_rect_writer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .abort     (abort),
        .wr_grant  (wr_grant),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .ramIn     (ramIn),
        .ramIn2    (ramIn2),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it until done, abort or the cycle budget.
    // gmask bit n is wr_grant in cycle n (1 beyond bit 63); abort is raised in
    // the cycle after abort_at writes have been observed (0 = never).
    task automatic run_cmd(input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1,
                           input logic [3:0] col, input logic [63:0] gmask,
                           input int abort_at, input int budget);
        int   n;
        logic fin;
        wr_q.delete();
        first_wr_n    = -1;
        done_n        = -1;
        gap_cnt       = 0;
        color_bad     = 0;
        timeout_f     = 1'b0;
        aborted_f     = 1'b0;
        abort_wr_en   = 1'b0;
        ready_in_done = 1'b1;
        cmd_x0    = x0;
        cmd_y0    = y0;
        cmd_x1    = x1;
        cmd_y1    = y1;
        cmd_color = col;
        cmd_valid = 1'b1;
        wr_grant  = 1'b1;
        #1;
        hs_ready = cmd_ready;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            wr_grant = (n < 64) ? gmask[n[5:0]] : 1'b1;
            abort    = (abort_at != 0) && (wr_q.size() == abort_at);
            #1;
            if (abort) begin
                abort_wr_en = wr_en;
                @(posedge Clk);
                #1;
                abort     = 1'b0;
                aborted_f = 1'b1;
                fin       = 1'b1;
            end else begin
                if (wr_en) begin
                    if (wr_q.size() != 0 && wr_addr != wr_q[$] + 17'd1) gap_cnt++;
                    if (first_wr_n < 0) first_wr_n = n;
                    if (ramIn !== col[1:0] || ramIn2 !== col[3:2]) color_bad++;
                    wr_q.push_back(wr_addr);
                end
                if (n < 64) addr_at[n[5:0]] = wr_addr;
                if (done) begin
                    done_n        = n;
                    ready_in_done = cmd_ready;
                    fin           = 1'b1;
                end else if (n >= budget) begin
                    timeout_f = 1'b1;
                    fin       = 1'b1;
                end else begin
                    @(posedge Clk);
                    #1;
                    n++;
                end
            end
        end
    endtask

    initial begin
        int k;
        Reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0    = 10'd0;
        cmd_y0    = 10'd0;
        cmd_x1    = 10'd0;
        cmd_y1    = 10'd0;
        cmd_color = 4'd0;
        abort     = 1'b0;
        wr_grant  = 1'b1;
        rev_exp[0] = 17'd888;
        rev_exp[1] = 17'd889;
        rev_exp[2] = 17'd890;
        rev_exp[3] = 17'd1328;
        rev_exp[4] = 17'd1329;
        rev_exp[5] = 17'd1330;

        // Reset values while reset is held.
        repeat (3) @(posedge Clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_wr_en",     32'(wr_en),     32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_ramIn",     32'(ramIn),     32'd0);
        check("rst_ramIn2",    32'(ramIn2),    32'd0);
        check("rst_done",      32'(done),      32'd0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Single pixel (5,2): 2*440+5 = 885.
        run_cmd(10'd5, 10'd2, 10'd5, 10'd2, 4'b1011, GRANT_ALL, 0, 20);
        check("px_hs_ready",   32'(hs_ready),    32'd1);
        check("px_timeout",    32'(timeout_f),   32'd0);
        check("px_nwrites",    32'(wr_q.size()), 32'd1);
        check("px_addr",       (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'd885);
        check("px_first_wr",   32'(first_wr_n),  32'd3);
        check("px_done_n",     32'(done_n),      32'd4);
        check("px_color",      32'(color_bad),   32'd0);
        check("px_ready_done", 32'(ready_in_done), 32'd0);
        @(posedge Clk);
        #1;
        check("px_ready_after", 32'(cmd_ready), 32'd1);
        check("px_busy_after",  32'(busy),      32'd0);

        // Reversed corners: x 8..10, y 2..3.
        run_cmd(10'd10, 10'd3, 10'd8, 10'd2, 4'b0001, GRANT_ALL, 0, 40);
        check("rev_nwrites", 32'(wr_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rev_addr%0d", i),
                  (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(rev_exp[i]));
        end
        check("rev_done_n", 32'(done_n), 32'd9);
        @(posedge Clk);
        #1;

        // Partial clip: x 430..439, y 275..279 -> 50 writes from 121430.
        run_cmd(10'd430, 10'd275, 10'd600, 10'd900, 4'b0111, GRANT_ALL, 0, 100);
        check("clip_nwrites", 32'(wr_q.size()), 32'd50);
        check("clip_first",   (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'd121430);
        check("clip_last",    (wr_q.size() > 0) ? 32'(wr_q[$]) : 32'hFFFF_FFFF, 32'd123199);
        check("clip_done_n",  32'(done_n), 32'd53);
        @(posedge Clk);
        #1;

        // Off-canvas: low x corner 500 is beyond the canvas, no writes.
        run_cmd(10'd500, 10'd0, 10'd600, 10'd10, 4'b0010, GRANT_ALL, 0, 20);
        check("empty_nwrites", 32'(wr_q.size()), 32'd0);
        check("empty_done_n",  32'(done_n),      32'd2);
        @(posedge Clk);
        #1;

        // Grant 1,0,0,1,... from the first WRITE cycle (n=3) on (5,2)-(7,2).
        run_cmd(10'd5, 10'd2, 10'd7, 10'd2, 4'b1110, ~64'h30, 0, 30);
        check("gnt_nwrites", 32'(wr_q.size()), 32'd3);
        check("gnt_addr0",   (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'd885);
        check("gnt_addr1",   (wr_q.size() > 1) ? 32'(wr_q[1]) : 32'hFFFF_FFFF, 32'd886);
        check("gnt_addr2",   (wr_q.size() > 2) ? 32'(wr_q[2]) : 32'hFFFF_FFFF, 32'd887);
        check("gnt_hold4",   32'(addr_at[4]), 32'd886);
        check("gnt_hold5",   32'(addr_at[5]), 32'd886);
        check("gnt_done_n",  32'(done_n),     32'd8);
        @(posedge Clk);
        #1;

        // Bulk clear of the bottom 20 rows: 8800 consecutive writes.
        run_cmd(10'd0, 10'd260, 10'd439, 10'd279, 4'b0100, GRANT_ALL, 0, 9000);
        check("bulk_timeout", 32'(timeout_f),   32'd0);
        check("bulk_nwrites", 32'(wr_q.size()), 32'd8800);
        check("bulk_first",   (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'd114400);
        check("bulk_last",    (wr_q.size() > 0) ? 32'(wr_q[$]) : 32'hFFFF_FFFF, 32'd123199);
        check("bulk_gaps",    32'(gap_cnt),     32'd0);
        check("bulk_first_n", 32'(first_wr_n),  32'd3);
        check("bulk_done_n",  32'(done_n),      32'd8803);
        check("bulk_color",   32'(color_bad),   32'd0);
        @(posedge Clk);
        #1;

        // abort in IDLE together with a command: command still accepted.
        cmd_x0    = 10'd5;
        cmd_y0    = 10'd2;
        cmd_x1    = 10'd5;
        cmd_y1    = 10'd2;
        cmd_color = 4'b0101;
        cmd_valid = 1'b1;
        abort     = 1'b1;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd1);
        k = 0;
        while (busy && k < 20) begin
            @(posedge Clk);
            #1;
            k++;
        end
        check("idle_abort_drain", 32'(busy), 32'd0);

        // abort after 4 writes of a full-canvas fill.
        run_cmd(10'd0, 10'd0, 10'd439, 10'd279, 4'b0011, GRANT_ALL, 4, 100);
        check("abt_taken",    32'(aborted_f),   32'd1);
        check("abt_wr_en",    32'(abort_wr_en), 32'd0);
        check("abt_nwrites",  32'(wr_q.size()), 32'd4);
        check("abt_last",     (wr_q.size() > 0) ? 32'(wr_q[$]) : 32'hFFFF_FFFF, 32'd3);
        check("abt_no_done",  32'(done_n),      32'hFFFF_FFFF);
        check("abt_done_out", 32'(done),        32'd0);
        check("abt_ready",    32'(cmd_ready),   32'd1);
        check("abt_busy",     32'(busy),        32'd0);
        run_cmd(10'd9, 10'd1, 10'd9, 10'd1, 4'b0110, GRANT_ALL, 0, 20);
        check("abt_next_nwrites", 32'(wr_q.size()), 32'd1);
        check("abt_next_addr", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'd449);
        check("abt_next_done", 32'(done_n), 32'd4);
        @(posedge Clk);
        #1;

        // Reset pulsed low mid-WRITE, away from a clock edge.
        cmd_x0    = 10'd0;
        cmd_y0    = 10'd0;
        cmd_x1    = 10'd439;
        cmd_y1    = 10'd279;
        cmd_color = 4'b1111;
        cmd_valid = 1'b1;
        wr_grant  = 1'b1;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        repeat (8) @(posedge Clk);
        #2;
        check("mid_pre_wr_en", 32'(wr_en),   32'd1);
        check("mid_pre_addr",  32'(wr_addr), 32'd5);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en",  32'(wr_en),     32'd0);
        check("mid_rst_addr",   32'(wr_addr),   32'd0);
        check("mid_rst_busy",   32'(busy),      32'd0);
        check("mid_rst_ready",  32'(cmd_ready), 32'd1);
        check("mid_rst_ramIn",  32'(ramIn),     32'd0);
        check("mid_rst_ramIn2", 32'(ramIn2),    32'd0);
        check("mid_rst_done",   32'(done),      32'd0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
